horner_activation_engine: RTL and testbench



---
 rtl/horner_activation_engine.sv | 185 ++++++++++++++++++
 tb/tb_horner_activation_engine.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/horner_activation_engine.sv
// Sequential Horner evaluator: Result = Offset + sum(CoeffNN * x^NN), one MAC per clock.
// Define HORNER_SAT_EN for saturating arithmetic with a sticky Overflow flag; otherwise results wrap.
module horner_activation_engine #(
   parameter int Width    = 32,
   parameter int FracBits = 16
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Start,
   input  logic [Width-1:0] InDato,
   input  logic [Width-1:0] Coeff00,
   input  logic [Width-1:0] Coeff01,
   input  logic [Width-1:0] Coeff02,
   input  logic [Width-1:0] Coeff03,
   input  logic [Width-1:0] Coeff04,
   input  logic [Width-1:0] Coeff05,
   input  logic [Width-1:0] Coeff06,
   input  logic [Width-1:0] Coeff07,
   input  logic [Width-1:0] Coeff08,
   input  logic [Width-1:0] Coeff09,
   input  logic [Width-1:0] Coeff10,
   input  logic [Width-1:0] Coeff11,
   input  logic [Width-1:0] Coeff12,
   input  logic [Width-1:0] Coeff13,
   input  logic [Width-1:0] Coeff14,
   input  logic [Width-1:0] Coeff15,
   input  logic [Width-1:0] Coeff16,
   input  logic [Width-1:0] Coeff17,
   input  logic [Width-1:0] Coeff18,
   input  logic [Width-1:0] Coeff19,
   input  logic [Width-1:0] Offset,
   output logic [Width-1:0] Result,
   output logic             Done,
   output logic             Busy,
   output logic             ClearStart,
   output logic             Overflow
);

`ifdef HORNER_SAT_EN
   localparam bit SatEn = 1'b1;
`else
   localparam bit SatEn = 1'b0;
`endif

   localparam logic [Width-1:0] SAT_MAX = {1'b0, {(Width-1){1'b1}}};
   localparam logic [Width-1:0] SAT_MIN = {1'b1, {(Width-1){1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ITER,
      ST_BIAS,
      ST_DONE,
      ST_WAITLOW
   } state_t;

   state_t state, next_state;

   logic signed [Width-1:0]   acc;
   logic signed [Width-1:0]   xreg;
   logic        [4:0]         idx;

   logic        [Width-1:0]   coeff [20];
   logic        [Width-1:0]   coeff_sel;
   logic signed [2*Width-1:0] shifted;
   logic        [Width:0]     mul_hi;
   logic        [Width-1:0]   mul_term;
   logic        [Width:0]     mac_wide;
   logic        [Width-1:0]   mac_next;
   logic        [Width:0]     bias_wide;
   logic        [Width-1:0]   bias_next;
   logic                      mul_clamp;
   logic                      mac_clamp;
   logic                      bias_clamp;

   assign coeff[0]  = Coeff00;
   assign coeff[1]  = Coeff01;
   assign coeff[2]  = Coeff02;
   assign coeff[3]  = Coeff03;
   assign coeff[4]  = Coeff04;
   assign coeff[5]  = Coeff05;
   assign coeff[6]  = Coeff06;
   assign coeff[7]  = Coeff07;
   assign coeff[8]  = Coeff08;
   assign coeff[9]  = Coeff09;
   assign coeff[10] = Coeff10;
   assign coeff[11] = Coeff11;
   assign coeff[12] = Coeff12;
   assign coeff[13] = Coeff13;
   assign coeff[14] = Coeff14;
   assign coeff[15] = Coeff15;
   assign coeff[16] = Coeff16;
   assign coeff[17] = Coeff17;
   assign coeff[18] = Coeff18;
   assign coeff[19] = Coeff19;

   // Full-width signed product (operands sign-extended by hand), then floor-shift by FracBits.
   always_comb begin
      coeff_sel = coeff[idx];
      shifted   = $signed({{Width{acc[Width-1]}}, acc} * {{Width{xreg[Width-1]}}, xreg}) >>> FracBits;

      // Product fits in Width bits only if its top Width+1 bits are all equal.
      mul_hi    = shifted[2*Width-1:Width-1];
      mul_clamp = !((&mul_hi) || !(|mul_hi));
      mul_term  = (SatEn && mul_clamp) ? (shifted[2*Width-1] ? SAT_MIN : SAT_MAX)
                                       : shifted[Width-1:0];

      mac_wide  = {mul_term[Width-1], mul_term} + {coeff_sel[Width-1], coeff_sel};
      mac_clamp = mac_wide[Width] ^ mac_wide[Width-1];
      mac_next  = (SatEn && mac_clamp) ? (mac_wide[Width] ? SAT_MIN : SAT_MAX)
                                       : mac_wide[Width-1:0];

      bias_wide  = {acc[Width-1], acc} + {Offset[Width-1], Offset};
      bias_clamp = bias_wide[Width] ^ bias_wide[Width-1];
      bias_next  = (SatEn && bias_clamp) ? (bias_wide[Width] ? SAT_MIN : SAT_MAX)
                                         : bias_wide[Width-1:0];
   end

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // NOTE: every signal gets a default first so no path through the case infers a latch.
   always_comb begin
      next_state = state;
      Busy       = 1'b0;
      Done       = 1'b0;
      ClearStart = 1'b0;
      case (state)
         ST_IDLE:    if (Start) next_state = ST_LOAD;
         ST_LOAD: begin
            Busy       = 1'b1;
            next_state = ST_ITER;
         end
         ST_ITER: begin
            Busy = 1'b1;
            if (idx == 5'd0) next_state = ST_BIAS;
         end
         ST_BIAS: begin
            Busy       = 1'b1;
            next_state = ST_DONE;
         end
         ST_DONE: begin
            Busy       = 1'b1;
            Done       = 1'b1;
            ClearStart = 1'b1;
            next_state = ST_WAITLOW;
         end
         ST_WAITLOW: if (!Start) next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         acc      <= '0;
         xreg     <= '0;
         idx      <= '0;
         Result   <= '0;
         Overflow <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               xreg     <= InDato;
               acc      <= Coeff19;
               idx      <= 5'd18;
               Overflow <= 1'b0;
            end
            ST_ITER: begin
               acc <= mac_next;
               if (idx != 5'd0) idx <= idx - 5'd1;
               if (SatEn && (mul_clamp || mac_clamp)) Overflow <= 1'b1;
            end
            ST_BIAS: begin
               Result <= bias_next;
               if (SatEn && bias_clamp) Overflow <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_horner_activation_engine.sv
// Directed self-checking bench for horner_activation_engine (Q16.16, expected values worked by hand).
module tb_horner_activation_engine;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        Start;
   logic [31:0] InDato;
   logic [31:0] Offset;
   logic [31:0] coeff [20];
   logic [31:0] Result;
   logic        Done;
   logic        Busy;
   logic        ClearStart;
   logic        Overflow;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   horner_activation_engine #(.Width(32), .FracBits(16)) dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .InDato(InDato),
      .Coeff00(coeff[0]),  .Coeff01(coeff[1]),  .Coeff02(coeff[2]),  .Coeff03(coeff[3]),
      .Coeff04(coeff[4]),  .Coeff05(coeff[5]),  .Coeff06(coeff[6]),  .Coeff07(coeff[7]),
      .Coeff08(coeff[8]),  .Coeff09(coeff[9]),  .Coeff10(coeff[10]), .Coeff11(coeff[11]),
      .Coeff12(coeff[12]), .Coeff13(coeff[13]), .Coeff14(coeff[14]), .Coeff15(coeff[15]),
      .Coeff16(coeff[16]), .Coeff17(coeff[17]), .Coeff18(coeff[18]), .Coeff19(coeff[19]),
      .Offset(Offset), .Result(Result), .Done(Done), .Busy(Busy),
      .ClearStart(ClearStart), .Overflow(Overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic set_all(input logic [31:0] v);
      for (int i = 0; i < 20; i++) coeff[i] = v;
   endtask

   // Starts one evaluation, checks latency and the DONE-cycle outputs, then the Done pulse width.
   task automatic run_eval(input string tag, input logic [31:0] x, input logic [31:0] off,
                           input logic [31:0] exp_res, input logic exp_ovf, input bit hold_start);
      int n;
      bit seen;
      @(negedge CLK);
      Start = 1'b0;
      repeat (2) @(negedge CLK);
      InDato = x;
      Offset = off;
      Start  = 1'b1;
      @(posedge CLK);
      #1 check({tag, "_busy_load"}, 32'(Busy), 32'd1);
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 40) begin
         @(posedge CLK);
         #1;
         n++;
         if (Done) seen = 1'b1;
      end
      check({tag, "_latency"}, n, 32'd21);
      check({tag, "_result"}, Result, exp_res);
      check({tag, "_overflow"}, 32'(Overflow), 32'(exp_ovf));
      check({tag, "_clearstart"}, 32'(ClearStart), 32'd1);
      check({tag, "_busy_done"}, 32'(Busy), 32'd1);
      if (!hold_start) begin
         @(negedge CLK);
         Start = 1'b0;
      end
      @(posedge CLK);
      #1 check({tag, "_done_pulse"}, {30'd0, Done, ClearStart}, 32'd0);
   endtask

   initial begin
      logic [31:0] acc_or;
      logic [31:0] sat_exp;
      logic        sat_ovf;
      bit          flag;

      Reset  = 1'b1;
      Start  = 1'b0;
      InDato = '0;
      Offset = '0;
      set_all(32'h0);
      #12;
      check("reset_outputs", {Result[31:4], Done, Busy, ClearStart, Overflow}, 32'd0);

      @(negedge CLK);
      Reset  = 1'b0;
      acc_or = '0;
      repeat (50) begin
         @(negedge CLK);
         acc_or |= Result | {28'd0, Done, Busy, ClearStart, Overflow};
      end
      check("idle_quiet", acc_or, 32'd0);

      // All coefficients 1.0, x = 1.0: twenty terms of 1.0 -> 20.0.
      set_all(32'h0001_0000);
      run_eval("ones", 32'h0001_0000, 32'h0, 32'h0014_0000, 1'b0, 1'b0);

      // x = 0 leaves only Coeff00 = 3.0, minus Offset 1.0 -> 2.0.
      for (int i = 1; i < 20; i++) coeff[i] = 32'h1111 * i;
      coeff[0] = 32'h0003_0000;
      run_eval("xzero", 32'h0, 32'hFFFF_0000, 32'h0002_0000, 1'b0, 1'b0);

      // x = 2.0, all 1.0: true value 2^20-1; wrap gives (2^36-2^16) mod 2^32.
`ifdef HORNER_SAT_EN
      sat_exp = 32'h7FFF_FFFF;
      sat_ovf = 1'b1;
`else
      sat_exp = 32'hFFFF_0000;
      sat_ovf = 1'b0;
`endif
      set_all(32'h0001_0000);
      run_eval("big", 32'h0002_0000, 32'h0, sat_exp, sat_ovf, 1'b1);

      // Start still high: WAITLOW must not re-enter LOAD.
      flag = 1'b0;
      repeat (10) begin
         @(posedge CLK);
         #1 flag |= Busy;
      end
      check("hold_no_rebusy", 32'(flag), 32'd0);

      // Coeff01 = 1 LSB, x = -0.5: (1 * -0.5) floors to -1 LSB.
      set_all(32'h0);
      coeff[1] = 32'h0000_0001;
      run_eval("floor", 32'hFFFF_8000, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);

      // Reset asserted in the 10th ITER cycle.
      set_all(32'h0001_0000);
      @(negedge CLK);
      Start = 1'b0;
      repeat (2) @(negedge CLK);
      InDato = 32'h0001_0000;
      Offset = 32'h0;
      Start  = 1'b1;
      @(posedge CLK);
      repeat (10) @(posedge CLK);
      #2 Reset = 1'b1;
      #1 check("midreset_outputs", {Result[31:4], Done, Busy, ClearStart, Overflow}, 32'd0);
      Start = 1'b0;
      repeat (3) @(negedge CLK);
      Reset = 1'b0;
      flag  = 1'b0;
      repeat (30) begin
         @(posedge CLK);
         #1 flag |= Done | ClearStart | Busy;
      end
      check("midreset_no_done", 32'(flag), 32'd0);

      run_eval("after_reset", 32'h0001_0000, 32'h0, 32'h0014_0000, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
